// File: rtl/data_gen.sv
// Pattern generator: emits len beats of increment/decrement/constant/LFSR data on a valid/ready port.
// First beat registered one cycle after start; ovalid/odata/olast hold while oready is low.
module data_gen #(
    parameter int unsigned              DATA_WIDTH = 8,
    parameter int unsigned              LEN_WIDTH  = 8,
    parameter int unsigned              STEP       = 1,
    parameter logic [DATA_WIDTH-1:0]    LFSR_TAPS  = 8'hB8
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [1:0]              mode,
    input  logic [LEN_WIDTH-1:0]    len,
    input  logic [DATA_WIDTH-1:0]   seed,
    input  logic                    oready,
    output logic                    ovalid,
    output logic [DATA_WIDTH-1:0]   odata,
    output logic                    olast,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] STEP_W = DATA_WIDTH'(STEP);
    localparam logic [DATA_WIDTH-1:0] ONE_W  = DATA_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  ONE_L  = LEN_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [1:0]              mode_q,  mode_d;
    logic [LEN_WIDTH-1:0]    len_q,   len_d;
    logic [LEN_WIDTH-1:0]    cnt_q,   cnt_d;
    logic [DATA_WIDTH-1:0]   data_q,  data_d;
    logic                    vld_q,   vld_d;
    logic                    last_q,  last_d;
    logic                    busy_q,  busy_d;
    logic                    done_q,  done_d;

    function automatic logic [DATA_WIDTH-1:0] next_word(input logic [1:0] m,
                                                        input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        case (m)
            2'd0:    r = d + STEP_W;
            2'd1:    r = d - STEP_W;
            2'd2:    r = d;
            default: r = {1'b0, d[DATA_WIDTH-1:1]} ^ (d[0] ? LFSR_TAPS : '0);
        endcase
        return r;
    endfunction

    // cnt_q holds the 1-based number of the beat currently presented.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        vld_d   = vld_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_d = RUN;
                    mode_d  = mode;
                    len_d   = len;
                    cnt_d   = ONE_L;
                    // An all-zero LFSR state would lock up, so seed 0 starts at 1.
                    data_d  = ((mode == 2'd3) && (seed == '0)) ? ONE_W : seed;
                    vld_d   = 1'b1;
                    last_d  = (len == ONE_L);
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (vld_q && oready) begin
                    if (last_q) begin
                        state_d = DONE;
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        data_d  = next_word(mode_q, data_q);
                        cnt_d   = cnt_q + ONE_L;
                        last_d  = ((cnt_q + ONE_L) == len_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ovalid = vld_q;
    assign odata  = data_q;
    assign olast  = last_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_data_gen.sv
// Directed bench for data_gen: pattern sequences, handshake stalls, abort, reset and len=0 handling.
module tb_data_gen;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic [7:0] len;
    logic [7:0] seed;
    logic       oready;
    logic       ovalid;
    logic [7:0] odata;
    logic       olast;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 sys_clk = ~sys_clk;

    data_gen dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (start),
        .abort   (abort),
        .mode    (mode),
        .len     (len),
        .seed    (seed),
        .oready  (oready),
        .ovalid  (ovalid),
        .odata   (odata),
        .olast   (olast),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [7:0] d, input logic l);
        chk({tag, ".ovalid"}, 32'(ovalid), 32'd1);
        chk({tag, ".odata"},  32'(odata),  32'(d));
        chk({tag, ".olast"},  32'(olast),  32'(l));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ovalid"}, 32'(ovalid), 32'd0);
        chk({tag, ".busy"},   32'(busy),   32'd0);
        chk({tag, ".done"},   32'(done),   32'd0);
    endtask

    logic [7:0] exp_dec [3]  = '{8'h03, 8'h02, 8'h01};
    logic [7:0] exp_lfsr [5] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};
    logic [7:0] exp_inc [4]  = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    initial begin
        int hs;
        int done_cnt;
        sys_rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
        len = 8'd0; seed = 8'd0; oready = 1'b0;
        tick(); tick();
        sys_rst = 1'b0;
        chk("rst.odata", 32'(odata), 32'd0);
        chk("rst.olast", 32'(olast), 32'd0);
        chk_idle("rst");

        // Increment with wrap; inputs scrambled while busy must not matter.
        mode = 2'd0; seed = 8'hFE; len = 8'd4; oready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; mode = 2'd1; seed = 8'h33; len = 8'd1;
        for (int i = 0; i < 4; i++) begin
            chk_beat($sformatf("inc%0d", i), exp_inc[i], i == 3);
            chk("inc.busy", 32'(busy), 32'd1);
            tick();
        end
        chk("inc.done_vld", 32'(ovalid), 32'd0);
        chk("inc.done", 32'(done), 32'd1);
        chk("inc.done_busy", 32'(busy), 32'd1);
        start = 1'b1;  // must be ignored in DONE
        tick();
        start = 1'b0;
        chk_idle("inc.after");
        tick();
        chk_idle("inc.after2");

        // Decrement with oready toggling; count handshakes in the bench.
        mode = 2'd1; seed = 8'd3; len = 8'd3; oready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        hs = 0; done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            oready = (i % 2 == 0);
            if (ovalid) begin
                chk($sformatf("dec.d%0d", i), 32'(odata), 32'(exp_dec[hs < 3 ? hs : 2]));
                chk($sformatf("dec.l%0d", i), 32'(olast), 32'(hs == 2));
                if (oready) hs++;
            end
            if (done) done_cnt++;
            tick();
        end
        chk("dec.handshakes", 32'(hs), 32'd3);
        chk("dec.done_pulses", 32'(done_cnt), 32'd1);
        oready = 1'b0;

        // Galois LFSR from seed 0.
        mode = 2'd3; seed = 8'd0; len = 8'd5; oready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_beat($sformatf("lfsr%0d", i), exp_lfsr[i], i == 4);
            tick();
        end
        chk("lfsr.done", 32'(done), 32'd1);
        tick();

        // Constant, single beat.
        mode = 2'd2; seed = 8'h5A; len = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk_beat("const", 8'h5A, 1'b1);
        tick();
        chk("const.done", 32'(done), 32'd1);
        chk("const.vld", 32'(ovalid), 32'd0);
        tick();

        // Start with len=0 is ignored.
        len = 8'd0; start = 1'b1;
        tick();
        chk_idle("len0.a");
        tick();
        start = 1'b0;
        chk_idle("len0.b");

        // Abort on beat 3 with a simultaneous handshake.
        mode = 2'd0; seed = 8'h20; len = 8'd10; oready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk_beat("ab.b1", 8'h20, 1'b0);
        tick();
        chk_beat("ab.b2", 8'h21, 1'b0);
        tick();
        chk_beat("ab.b3", 8'h22, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("ab.post");
        chk("ab.olast", 32'(olast), 32'd0);
        tick();
        chk_idle("ab.post2");
        // Abort in IDLE has no effect: start alongside it still launches.
        seed = 8'h40; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_beat("ab.restart", 8'h40, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("ab.clean");

        // Reset during beat 2.
        mode = 2'd0; seed = 8'h10; len = 8'd6; start = 1'b1;
        tick();
        start = 1'b0;
        chk_beat("rs.b1", 8'h10, 1'b0);
        tick();
        chk_beat("rs.b2", 8'h11, 1'b0);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("rs.odata", 32'(odata), 32'd0);
        chk("rs.olast", 32'(olast), 32'd0);
        chk_idle("rs.post");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle($sformatf("rs.quiet%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
